// File: rtl/avalon_burst_reader_if.sv
// Avalon-MM bus bundle shared by burst hosts and block-RAM agents.
interface avalon_if #(
  parameter int unsigned BURSTCOUNT_W = 4
) (
  input logic clk,
  input logic reset
);
  logic [31:0]             address;
  logic                    read;
  logic                    write;
  logic [31:0]             writedata;
  logic [3:0]              byteenable;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic [31:0]             readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport host (
    input  clk, reset, readdata, readdatavalid, waitrequest,
    output address, read, write, writedata, byteenable, burstcount
  );

  modport agent (
    input  clk, reset, address, read, write, writedata, byteenable, burstcount,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_burst_reader.sv
// Avalon-MM burst read host: splits a word-block read into bursts, buffers the
// returned beats in a show-ahead FIFO and streams them out on valid/ready.
module avalon_burst_reader #(
  parameter int unsigned RAM_ADD_W    = 11,
  parameter int unsigned BURSTCOUNT_W = 4,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned LEN_W        = 16
) (
  avalon_if.host            avalon_h,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int unsigned DEPTH     = 2 ** FIFO_AW;
  localparam int unsigned MAX_BURST = 2 ** (BURSTCOUNT_W - 1);
  localparam int unsigned CW        = FIFO_AW + 1;

  if (DEPTH < MAX_BURST || RAM_ADD_W == 0) begin : g_param_check
    $error("avalon_burst_reader: FIFO must hold at least one full burst");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [BURSTCOUNT_W-1:0] burst_len_q, burst_len_d;
  logic [BURSTCOUNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                    read_q, read_d;
  logic [31:0]             address_q, address_d;
  logic [BURSTCOUNT_W-1:0] burstcount_q, burstcount_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    out_valid_q, out_valid_d;

  logic [31:0]             mem [DEPTH];
  logic                    push, pop;
  logic [CW-1:0]           free_c;
  logic                    arm;
  logic [31:0]             arm_addr;
  logic [LEN_W-1:0]        arm_rem;
  logic [BURSTCOUNT_W-1:0] next_bl;
  logic [31:0]             next_addr;
  logic [LEN_W-1:0]        next_rem;

  function automatic logic [BURSTCOUNT_W-1:0] clip_burst(input logic [LEN_W-1:0] n);
    if (n >= LEN_W'(MAX_BURST)) return BURSTCOUNT_W'(MAX_BURST);
    return BURSTCOUNT_W'(n);
  endfunction

  // FIFO bookkeeping; free space is judged on next-cycle occupancy
  always_comb begin
    push        = (state_q == S_DATA) && avalon_h.readdatavalid;
    pop         = out_valid_q && out_ready;
    wr_ptr_d    = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d    = rd_ptr_q + FIFO_AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    out_valid_d = (count_d != '0);
    free_c      = CW'(DEPTH) - count_d;
  end

  // Control FSM; "arm" sets up the next burst and reserves FIFO space for it
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    burst_len_d  = burst_len_q;
    beat_cnt_d   = beat_cnt_q;
    read_d       = read_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    arm          = 1'b0;
    arm_addr     = cur_addr_q;
    arm_rem      = remaining_q;
    next_bl      = '0;
    next_addr    = cur_addr_q + (32'(burst_len_q) << 2);
    next_rem     = remaining_q - LEN_W'(burst_len_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (len_words != '0) begin
            cur_addr_d  = {base_addr[31:2], 2'b00};
            remaining_d = len_words;
            arm         = 1'b1;
            arm_addr    = {base_addr[31:2], 2'b00};
            arm_rem     = len_words;
            state_d     = S_CMD;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_CMD: begin
        if (read_q) begin
          if (!avalon_h.waitrequest) begin
            read_d     = 1'b0;
            beat_cnt_d = '0;
            state_d    = S_DATA;
          end
        end else begin
          arm = 1'b1;
        end
      end
      S_DATA: begin
        if (avalon_h.readdatavalid) begin
          beat_cnt_d = beat_cnt_q + BURSTCOUNT_W'(1);
          if (beat_cnt_q + BURSTCOUNT_W'(1) == burst_len_q) begin
            cur_addr_d  = next_addr;
            remaining_d = next_rem;
            if (next_rem == '0) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              arm      = 1'b1;
              arm_addr = next_addr;
              arm_rem  = next_rem;
              state_d  = S_CMD;
            end
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (arm) begin
      next_bl      = clip_burst(arm_rem);
      burst_len_d  = next_bl;
      address_d    = arm_addr;
      burstcount_d = next_bl;
      read_d       = (32'(free_c) >= 32'(next_bl));
    end
  end

  always_ff @(posedge avalon_h.clk or posedge avalon_h.reset) begin
    if (avalon_h.reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      burst_len_q  <= '0;
      beat_cnt_q   <= '0;
      read_q       <= 1'b0;
      address_q    <= '0;
      burstcount_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      burst_len_q  <= burst_len_d;
      beat_cnt_q   <= beat_cnt_d;
      read_q       <= read_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // FIFO storage needs no reset; pointers and occupancy define validity
  always_ff @(posedge avalon_h.clk) begin
    if (push) mem[wr_ptr_q] <= avalon_h.readdata;
  end

  assign avalon_h.read       = read_q;
  assign avalon_h.address    = address_q;
  assign avalon_h.burstcount = burstcount_q;
  assign avalon_h.write      = 1'b0;
  assign avalon_h.writedata  = '0;
  assign avalon_h.byteenable = 4'hF;

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem[rd_ptr_q];
endmodule

// File: tb/tb_avalon_burst_reader.sv
// Directed bench for avalon_burst_reader with a burst-capable memory agent model.
module tb_avalon_burst_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  avalon_if #(.BURSTCOUNT_W(4)) bus (.clk(clk), .reset(rst));

  avalon_burst_reader dut (
    .avalon_h (bus),
    .start    (start),
    .base_addr(base_addr),
    .len_words(len_words),
    .busy     (busy),
    .done     (done),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // Memory agent: optional waitrequest stall per command, beats back-to-back
  int          stall_cfg = 0;
  int          wait_ctr = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a = '0;
  logic [3:0]  hold_b = '0;
  logic        unstable = 1'b0;
  logic [31:0] cmd_a[$];
  int          cmd_b[$];

  assign bus.waitrequest = bus.read && (wait_ctr < stall_cfg);

  always @(posedge clk) begin
    if (bus.read && bus.waitrequest) begin
      wait_ctr <= wait_ctr + 1;
      if (!hold_v) begin
        hold_v <= 1'b1;
        hold_a <= bus.address;
        hold_b <= bus.burstcount;
      end else if (bus.address != hold_a || bus.burstcount != hold_b) begin
        unstable <= 1'b1;
      end
    end else if (bus.read) begin
      if (hold_v && (bus.address != hold_a || bus.burstcount != hold_b)) unstable <= 1'b1;
      hold_v    <= 1'b0;
      wait_ctr  <= 0;
      cmd_a.push_back(bus.address);
      cmd_b.push_back(int'(bus.burstcount));
      pend_addr <= bus.address;
      pend_cnt  <= int'(bus.burstcount);
    end
    if (pend_cnt > 0) begin
      bus.readdatavalid <= 1'b1;
      bus.readdata      <= mem_word(pend_addr);
      pend_addr         <= pend_addr + 32'd4;
      pend_cnt          <= pend_cnt - 1;
    end else begin
      bus.readdatavalid <= 1'b0;
    end
  end

  // Stream / event monitor
  logic [31:0] rx[$];
  int beats = 0;
  int done_cnt = 0;
  int read_cycles = 0;

  always @(posedge clk) begin
    if (bus.readdatavalid) beats <= beats + 1;
    if (out_valid && out_ready) rx.push_back(out_data);
    if (done) done_cnt <= done_cnt + 1;
    if (bus.read) read_cycles <= read_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [31:0] a, input int n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = a; len_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic chk_rx(input string tag, input int r0, input logic [31:0] first, input int n);
    chk({tag, "_count"}, 32'(rx.size() - r0), 32'(n));
    for (int i = 0; i < n && (r0 + i) < rx.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), rx[r0 + i], first + 32'(i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0, d0, b0, rc0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_burstcount", 32'(bus.burstcount), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_byteenable", 32'(bus.byteenable), 32'hF);
    @(posedge clk); #1 rst = 1'b0;

    // Single short read
    r0 = rx.size(); c0 = cmd_a.size(); d0 = done_cnt;
    cmd(32'h40, 3);
    chk("t1_read", 32'(bus.read), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_addr", bus.address, 32'h40);
    chk("t1_bc", 32'(bus.burstcount), 32'd3);
    wait_done("t1", 50);
    chk("t1_busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_done_drop", 32'(done), 32'd0);
    chk("t1_busy_drop", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk_rx("t1", r0, 32'hA000_0010, 3);
    chk("t1_ncmd", 32'(cmd_a.size() - c0), 32'd1);
    chk("t1_ndone", 32'(done_cnt - d0), 32'd1);

    // Multi-burst split
    r0 = rx.size(); c0 = cmd_a.size();
    cmd(32'h0, 20);
    wait_done("t2", 200);
    repeat (10) @(negedge clk);
    chk("t2_ncmd", 32'(cmd_a.size() - c0), 32'd3);
    if (cmd_a.size() - c0 == 3) begin
      chk("t2_a0", cmd_a[c0], 32'h00);     chk("t2_b0", 32'(cmd_b[c0]), 32'd8);
      chk("t2_a1", cmd_a[c0+1], 32'h20);   chk("t2_b1", 32'(cmd_b[c0+1]), 32'd8);
      chk("t2_a2", cmd_a[c0+2], 32'h40);   chk("t2_b2", 32'(cmd_b[c0+2]), 32'd4);
    end
    chk_rx("t2", r0, 32'hA000_0000, 20);

    // Waitrequest stalls
    stall_cfg = 5;
    r0 = rx.size(); c0 = cmd_a.size();
    cmd(32'h100, 10);
    wait_done("t3", 300);
    repeat (10) @(negedge clk);
    stall_cfg = 0;
    chk("t3_stable", 32'(unstable), 32'd0);
    chk("t3_ncmd", 32'(cmd_a.size() - c0), 32'd2);
    if (cmd_a.size() - c0 == 2) begin
      chk("t3_a0", cmd_a[c0], 32'h100);    chk("t3_b0", 32'(cmd_b[c0]), 32'd8);
      chk("t3_a1", cmd_a[c0+1], 32'h120);  chk("t3_b1", 32'(cmd_b[c0+1]), 32'd2);
    end
    chk_rx("t3", r0, 32'hA000_0040, 10);

    // Backpressure: FIFO fills to 16 and fetching stops
    out_ready = 1'b0;
    r0 = rx.size(); c0 = cmd_a.size(); b0 = beats;
    cmd(32'h0, 40);
    repeat (150) @(negedge clk);
    chk("t4_beats_held", 32'(beats - b0), 32'd16);
    chk("t4_ncmd_held", 32'(cmd_a.size() - c0), 32'd2);
    chk("t4_read_held", 32'(bus.read), 32'd0);
    chk("t4_valid_held", 32'(out_valid), 32'd1);
    chk("t4_head", out_data, 32'hA000_0000);
    chk("t4_busy_held", 32'(busy), 32'd1);
    out_ready = 1'b1;
    wait_done("t4", 600);
    repeat (25) @(negedge clk);
    chk("t4_ncmd", 32'(cmd_a.size() - c0), 32'd5);
    chk("t4_beats", 32'(beats - b0), 32'd40);
    chk_rx("t4", r0, 32'hA000_0000, 40);

    // Zero-length command
    c0 = cmd_a.size(); d0 = done_cnt; rc0 = read_cycles;
    cmd(32'h80, 0);
    wait_done("t5", 10);
    repeat (5) @(negedge clk);
    chk("t5_ndone", 32'(done_cnt - d0), 32'd1);
    chk("t5_ncmd", 32'(cmd_a.size() - c0), 32'd0);
    chk("t5_read_cycles", 32'(read_cycles - rc0), 32'd0);

    // Unaligned base is forced to word alignment
    r0 = rx.size(); c0 = cmd_a.size();
    cmd(32'h43, 1);
    chk("t6_addr", bus.address, 32'h40);
    chk("t6_bc", 32'(bus.burstcount), 32'd1);
    wait_done("t6", 50);
    repeat (5) @(negedge clk);
    chk_rx("t6", r0, 32'hA000_0010, 1);

    // start while busy is ignored
    r0 = rx.size(); c0 = cmd_a.size(); d0 = done_cnt;
    cmd(32'h0, 4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h200; len_words = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t7", 50);
    repeat (40) @(negedge clk);
    chk("t7_ndone", 32'(done_cnt - d0), 32'd1);
    chk("t7_ncmd", 32'(cmd_a.size() - c0), 32'd1);
    chk_rx("t7", r0, 32'hA000_0000, 4);

    // Reset mid-burst, then a fresh command
    out_ready = 1'b0;
    b0 = beats;
    cmd(32'h0, 8);
    for (int n = 0; n < 50 && (beats - b0) < 3; n++) @(negedge clk);
    chk("t8_beats_pre", 32'(beats - b0), 32'd3);
    chk("t8_valid_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t8_rst_read", 32'(bus.read), 32'd0);
    chk("t8_rst_valid", 32'(out_valid), 32'd0);
    chk("t8_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t8_late_valid", 32'(out_valid), 32'd0);
    chk("t8_late_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    r0 = rx.size();
    cmd(32'h80, 5);
    wait_done("t8", 50);
    repeat (10) @(negedge clk);
    chk_rx("t8", r0, 32'hA000_0020, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avalon_burst_reader.md
# avalon_burst_reader

Avalon-MM host that streams a contiguous block of 32-bit words out of an Avalon agent memory using burst reads. A command (byte base address, word count) is issued on a start pulse. The block splits the transfer into bursts of at most 2**(BURSTCOUNT_W-1) words, buffers returned data in an internal FIFO, and presents it on a valid/ready stream. It is the initiating end of the same Avalon interface the team's block-RAM agents implement.

## Interface
- RAM_ADD_W, 11: address-space size of the target, in words; informational, not used for wrap.
- BURSTCOUNT_W, 4: width of burstcount; maximum burst is 2**(BURSTCOUNT_W-1) = 8 words.
- FIFO_AW, 4: FIFO depth is 2**FIFO_AW = 16 words; must satisfy 2**FIFO_AW >= 2**(BURSTCOUNT_W-1).
- LEN_W, 16: width of the word-count field.
- avalon_h.clk  in  1  single clock; all logic is on its rising edge (carried in avalon_if).
- avalon_h.reset  in  1  asynchronous, active-high reset (carried in avalon_if).
- avalon_h  host modport  -  avalon_if; drives address[31:0], read, write, writedata[31:0], byteenable[3:0], burstcount[BURSTCOUNT_W-1:0]; samples readdata[31:0], readdatavalid, waitrequest.
- start  in  1  one-cycle command strobe.
- base_addr  in  32  byte address of the first word; bits [1:0] are forced to 0.
- len_words  in  LEN_W  number of words to read.
- busy  out  1  high from command acceptance until the last beat is received.
- done  out  1  one-cycle pulse when the transfer completes.
- out_data  out  32  FIFO head word (show-ahead).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.

## Operation
- Constant outputs: write=0, writedata=0, byteenable=4'hF.
- Registers: cur_addr (32), remaining (LEN_W), burst_len, beat_cnt, FIFO pointers and occupancy count (FIFO_AW+1 bits).
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE: on start with len_words != 0, latch cur_addr = {base_addr[31:2],2'b00} and remaining = len_words, then go to CMD. With len_words == 0, go to DONE and issue no bus transaction. start is ignored in every state other than IDLE.
- CMD:
  - burst_len = min(remaining, 2**(BURSTCOUNT_W-1)).
  - Assert read only when FIFO free space (depth - occupancy) >= burst_len. Otherwise hold read=0 and wait.
  - While read=1, address=cur_addr and burstcount=burst_len are held stable.
  - The command is accepted on the first edge with read=1 && waitrequest=0. Then deassert read next cycle, clear beat_cnt and go to DATA.
- DATA:
  - Each cycle with readdatavalid=1 pushes readdata into the FIFO and increments beat_cnt.
  - readdatavalid is ignored outside DATA.
  - On the last beat (beat_cnt+1 == burst_len): cur_addr += 4*burst_len, remaining -= burst_len. Go to DONE if the new remaining is 0, else go to CMD.
- Only one burst is outstanding at any time.
- DONE: assert done for one cycle, deassert busy, return to IDLE. FIFO contents stay valid and continue to drain.
- FIFO:
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - Overflow cannot occur because of the space reservation in CMD.
  - Pop on an empty FIFO is ignored.
- Address arithmetic is 32-bit and wraps modulo 2**32 silently.

## Timing
- Reset values: read=0, address=0, burstcount=0, busy=0, done=0, out_valid=0. FIFO is empty and FSM is in IDLE.
- Reset mid-transfer aborts immediately: read drops asynchronously and the FIFO is flushed. Late readdatavalid after reset release is ignored, because the FSM is in IDLE.
- start at edge T: busy=1 and read=1 from T+1 if FIFO space allows.
- Command accepted at edge A: read=0 from A+1.
- Each beat is visible on out_valid one cycle after its readdatavalid edge.
- Last beat at edge L: done=1 during cycle L+1 to L+2 (DONE state). busy=0 from L+2. Earliest next command is at L+2.
- Minimum back-to-back burst gap: read reasserts the cycle after the last beat of the previous burst.

## Test plan
- Single short read: memory preloaded with word i = 32'hA000_0000+i; start, base=0x40, len=3 -> one command with address=0x40 and burstcount=3, then out stream A000_0010, A000_0011, A000_0012, then one done pulse.
- Multi-burst split: base=0, len=20, out_ready=1 -> commands at 0x00/8, 0x20/8, 0x40/4; 20 words in order; busy falls after the 20th beat.
- Waitrequest stalls: agent holds waitrequest=1 for 5 cycles per command -> address and burstcount stay stable throughout; no duplicate command; data correct.
- Backpressure: len=40, out_ready=0 -> exactly 16 words fetched (two 8-bursts), then read stays 0. Raising out_ready resumes fetching; no word is lost or duplicated.
- Edge commands: len=0 -> done pulse, no read asserted. base=0x43 -> first address is 0x40. start while busy -> ignored, no extra done.
- Reset mid-burst: assert reset after beat 3 of 8 -> read=0, out_valid=0 immediately. A new command after reset completes correctly.
